lsu: RTL

Load/store unit sitting directly downstream of the execute stage. It accepts one memory operation at a time on the execute stage's load/store request channel and issues it as a single word-aligned access on the data-memory bus. It returns formatted load data, or a store acknowledge, on the load/store response channel. Misaligned accesses are trapped locally and answered with an error flag without touching memory.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 102 ++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MEM_AW = 30;
    localparam int unsigned NBYTE  = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } ldst_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RSP   = 2'd3
    } lsu_state_e;

    // size is kept as raw bits: encoding 3 is reserved but can still arrive
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            st;
        logic [1:0]      size;
        logic            uns;
    } ldst_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } ldst_rsp_t;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic              we;
        logic [NBYTE-1:0]  wstrb;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
    } mem_rsp_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            SZ_W:    mis = |lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready channels between execute stage, LSU and data memory.
interface ldst_req_if_t;
    logic               vld;
    logic               rdy;
    lsu_pkg::ldst_req_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface ldst_rsp_if_t;
    logic               vld;
    logic               rdy;
    lsu_pkg::ldst_rsp_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface mem_req_if_t;
    logic              vld;
    logic              rdy;
    lsu_pkg::mem_req_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface mem_rsp_if_t;
    logic              vld;
    logic              rdy;
    lsu_pkg::mem_rsp_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, misalignment detect.
module lsu_align
    import lsu_pkg::*;
(
    input  logic             st_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [NBYTE-1:0] wstrb_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             misaligned_o
);

    logic [XLEN-1:0] sh;

    assign misaligned_o = is_misaligned(size_i, addr_lo_i);

    always_comb begin
        wstrb_o = '0;
        wdata_o = '0;
        rdata_o = '0;
        sh      = rdata_i >> {addr_lo_i, 3'b000};
        if (st_i) begin
            case (size_i)
                SZ_B: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SZ_H: begin
                    wstrb_o = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    wstrb_o = 4'hF;
                    wdata_o = wdata_i;
                end
            endcase
        end else begin
            case (size_i)
                SZ_B:    rdata_o = {{24{~uns_i & sh[7]}}, sh[7:0]};
                SZ_H:    rdata_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
                default: rdata_o = sh;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one op in flight, word-aligned memory access, local misalign trap.
module lsu
    import lsu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    ldst_req_if_t.slv ldst_req_slv,
    ldst_rsp_if_t.mst ldst_rsp_mst,
    mem_req_if_t.mst  mem_req_mst,
    mem_rsp_if_t.slv  mem_rsp_slv
);

    lsu_state_e state_q, state_d;
    ldst_req_t  op_q, op_d, al_op;
    ldst_rsp_t  res_q, res_d;
    logic       req_rdy_q, mreq_vld_q, mrsp_rdy_q, rsp_vld_q;

    logic [NBYTE-1:0] al_wstrb;
    logic [XLEN-1:0]  al_wdata, al_rdata;
    logic             al_mis;

    // In IDLE the aligner inspects the incoming op for the misalign trap;
    // afterwards it works from the latched op, so mem request fields stay stable.
    assign al_op = (state_q == IDLE) ? ldst_req_slv.pkt : op_q;

    lsu_align u_align (
        .st_i         (al_op.st),
        .size_i       (al_op.size),
        .uns_i        (al_op.uns),
        .addr_lo_i    (al_op.addr[1:0]),
        .wdata_i      (al_op.wdata),
        .rdata_i      (mem_rsp_slv.pkt.rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (ldst_req_slv.vld) begin
                    op_d = ldst_req_slv.pkt;
                    if (al_mis) begin
                        res_d   = '{rdata: '0, err: 1'b1};
                        state_d = RSP;
                    end else begin
                        state_d = MREQ;
                    end
                end
            end
            MREQ: begin
                if (mem_req_mst.rdy) state_d = MWAIT;
            end
            MWAIT: begin
                if (mem_rsp_slv.vld) begin
                    res_d   = '{rdata: al_rdata, err: 1'b0};
                    state_d = RSP;
                end
            end
            RSP: begin
                if (ldst_rsp_mst.rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            res_q      <= '0;
            req_rdy_q  <= 1'b1;
            mreq_vld_q <= 1'b0;
            mrsp_rdy_q <= 1'b0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            res_q      <= res_d;
            req_rdy_q  <= (state_d == IDLE);
            mreq_vld_q <= (state_d == MREQ);
            mrsp_rdy_q <= (state_d == MWAIT);
            rsp_vld_q  <= (state_d == RSP);
        end
    end

    assign ldst_req_slv.rdy = req_rdy_q;
    assign ldst_rsp_mst.vld = rsp_vld_q;
    assign ldst_rsp_mst.pkt = res_q;
    assign mem_req_mst.vld  = mreq_vld_q;
    assign mem_req_mst.pkt  = '{addr:  al_op.addr[XLEN-1:2],
                                we:    al_op.st,
                                wstrb: al_wstrb,
                                wdata: al_wdata};
    assign mem_rsp_slv.rdy  = mrsp_rdy_q;

endmodule
